// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, syncs, active-draw, new-frame pulse, frame count.
// Optional build macro SYNC_NEG_POL_EN makes hs_out/vs_out active-low (inactive/reset level 1).
module video_timing_gen #(
  parameter int ACTIVE_H = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int ACTIVE_V = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int FPS      = 60,
  localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP,
  localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(TOTAL_H),
  localparam int VW      = $clog2(TOTAL_V),
  localparam int FW      = $clog2(FPS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          en_in,
  output logic [HW-1:0] h_count_out,
  output logic [VW-1:0] v_count_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out,
  output logic          nf_out,
  output logic [FW-1:0] fc_out
);

`ifdef SYNC_NEG_POL_EN
  localparam logic SYNC_ACT = 1'b0;
`else
  localparam logic SYNC_ACT = 1'b1;
`endif

  localparam logic [HW-1:0] H_LAST   = HW'(TOTAL_H - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(TOTAL_V - 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(FPS - 1);
  localparam logic [31:0]   HS_START = 32'(ACTIVE_H + H_FP);
  localparam logic [31:0]   HS_END   = 32'(ACTIVE_H + H_FP + H_SYNC);
  localparam logic [31:0]   VS_START = 32'(ACTIVE_V + V_FP);
  localparam logic [31:0]   VS_END   = 32'(ACTIVE_V + V_FP + V_SYNC);
  localparam logic [31:0]   AH       = 32'(ACTIVE_H);
  localparam logic [31:0]   AV       = 32'(ACTIVE_V);

  // IDLE = not yet started (first enable presents (0,0)); RUN = advancing.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_next;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          hs_next, vs_next, ad_next, nf_next;
  logic [FW-1:0] fc_next;
  logic [31:0]   h_wide, v_wide;

  assign h_wide = 32'(h_next);
  assign v_wide = 32'(v_next);

  always_comb begin
    state_next = state;
    h_next     = h_count_out;
    v_next     = v_count_out;
    hs_next    = hs_out;
    vs_next    = vs_out;
    ad_next    = ad_out;
    nf_next    = 1'b0;
    fc_next    = fc_out;
    if (en_in) begin
      if (state == IDLE) begin
        state_next = RUN;
        h_next     = '0;
        v_next     = '0;
      end else if (h_count_out == H_LAST) begin
        h_next = '0;
        v_next = (v_count_out == V_LAST) ? '0 : v_count_out + VW'(1);
      end else begin
        h_next = h_count_out + HW'(1);
      end
      // Decode from the position being registered this cycle; compare wide so
      // a sync end equal to 2^HW cannot wrap.
      ad_next = (h_wide < AH) && (v_wide < AV);
      hs_next = ((h_wide >= HS_START) && (h_wide < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      vs_next = ((v_wide >= VS_START) && (v_wide < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      nf_next = (h_wide == AH) && (v_wide == AV);
      if (nf_next) fc_next = (fc_out == FC_LAST) ? '0 : fc_out + FW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      h_count_out <= '0;
      v_count_out <= '0;
      hs_out      <= ~SYNC_ACT;
      vs_out      <= ~SYNC_ACT;
      ad_out      <= 1'b0;
      nf_out      <= 1'b0;
      fc_out      <= '0;
    end else begin
      state       <= state_next;
      h_count_out <= h_next;
      v_count_out <= v_next;
      hs_out      <= hs_next;
      vs_out      <= vs_next;
      ad_out      <= ad_next;
      nf_out      <= nf_next;
      fc_out      <= fc_next;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: linear-pixel-index reference model checked every cycle,
// plus directed literal checks for reset, line sweep, frame end, fc wrap, enable gaps, mid reset.
module tb_video_timing_gen;
  localparam int ACTIVE_H = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int ACTIVE_V = 3, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int FPS = 3;
  localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;
  localparam int FRAME = TOTAL_H * TOTAL_V;
  localparam int HW = $clog2(TOTAL_H), VW = $clog2(TOTAL_V), FW = $clog2(FPS);
`ifdef SYNC_NEG_POL_EN
  localparam int SACT = 0;
`else
  localparam int SACT = 1;
`endif
  localparam int SINACT = 1 - SACT;

  logic          clk = 1'b0;
  logic          rst_in = 1'b0, en_in = 1'b0;
  logic [HW-1:0] h_count_out;
  logic [VW-1:0] v_count_out;
  logic          hs_out, vs_out, ad_out, nf_out;
  logic [FW-1:0] fc_out;

  int checks = 0;
  int errors = 0;

  video_timing_gen #(
    .ACTIVE_H(ACTIVE_H), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .ACTIVE_V(ACTIVE_V), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .FPS(FPS)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .en_in(en_in),
    .h_count_out(h_count_out), .v_count_out(v_count_out),
    .hs_out(hs_out), .vs_out(vs_out), .ad_out(ad_out),
    .nf_out(nf_out), .fc_out(fc_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Reference model: position as a single pixel index within the frame.
  bit m_known = 0, m_started = 0, m_zero = 1, m_nf = 0;
  int m_pos = 0, m_fc = 0;

  always @(posedge clk) begin
    if (!rst_in) begin
      m_known = 1; m_started = 0; m_zero = 1; m_nf = 0; m_pos = 0; m_fc = 0;
    end else if (en_in) begin
      if (!m_started) begin
        m_started = 1; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
      m_zero = 0;
      m_nf = (m_pos == ACTIVE_V * TOTAL_H + ACTIVE_H);
      if (m_nf) m_fc = (m_fc + 1) % FPS;
    end else begin
      m_nf = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle once a reset has established a known state.
  always @(negedge clk) begin
    int eh, ev, ead, ehs, evs;
    if (m_known) begin
      if (m_zero) begin
        eh = 0; ev = 0; ead = 0; ehs = SINACT; evs = SINACT;
      end else begin
        eh  = m_pos % TOTAL_H;
        ev  = m_pos / TOTAL_H;
        ead = (eh < ACTIVE_H && ev < ACTIVE_V) ? 1 : 0;
        ehs = (eh >= ACTIVE_H + H_FP && eh < ACTIVE_H + H_FP + H_SYNC) ? SACT : SINACT;
        evs = (ev >= ACTIVE_V + V_FP && ev < ACTIVE_V + V_FP + V_SYNC) ? SACT : SINACT;
      end
      check("model_h", int'(h_count_out), eh);
      check("model_v", int'(v_count_out), ev);
      check("model_ad", int'(ad_out), ead);
      check("model_hs", int'(hs_out), ehs);
      check("model_vs", int'(vs_out), evs);
      check("model_nf", int'(nf_out), int'(m_nf));
      check("model_fc", int'(fc_out), m_fc);
    end
  end

  // driver task: apply inputs, take one clock edge, settle past the edge
  task automatic cyc(input logic r, input logic e);
    rst_in = r; en_in = e;
    @(posedge clk); #1;
  endtask

  initial begin
    bit found;
    int nf_seen;
    int fc_expect[2] = '{2, 0};

    // 1. reset with en high
    repeat (3) cyc(1'b0, 1'b1);
    check("rst_h", int'(h_count_out), 0);
    check("rst_ad", int'(ad_out), 0);
    check("rst_hs", int'(hs_out), SINACT);
    check("rst_vs", int'(vs_out), SINACT);
    check("rst_nf", int'(nf_out), 0);
    check("rst_fc", int'(fc_out), 0);
    cyc(1'b1, 1'b1);
    check("start_h", int'(h_count_out), 0);
    check("start_v", int'(v_count_out), 0);
    check("start_ad", int'(ad_out), 1);
    check("start_hs", int'(hs_out), SINACT);
    check("start_nf", int'(nf_out), 0);

    // 2. line sweep
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b1);
      check("sweep_h", int'(h_count_out), i % 8);
      check("sweep_v", int'(v_count_out), (i == 8) ? 1 : 0);
      check("sweep_ad", int'(ad_out), (i % 8 <= 3) ? 1 : 0);
      check("sweep_hs", int'(hs_out), (i == 5 || i == 6) ? SACT : SINACT);
    end

    // 3. frame end
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1'b1, 1'b1);
      if (v_count_out == 4) check("vline_vs", int'(vs_out), SACT);
      if (nf_out) begin
        found = 1;
        check("nf_h", int'(h_count_out), 4);
        check("nf_v", int'(v_count_out), 3);
        check("nf_fc", int'(fc_out), 1);
      end
    end
    check("nf_found", int'(found), 1);

    // 4. frame counter wrap: next two pulses give 2 then 0
    nf_seen = 0;
    for (int i = 0; i < 4 * FRAME && nf_seen < 2; i++) begin
      cyc(1'b1, 1'b1);
      if (nf_out) begin
        check("fc_wrap", int'(fc_out), fc_expect[nf_seen]);
        nf_seen++;
      end
    end
    check("fc_pulses", nf_seen, 2);

    // 5. enable gaps across the nf point
    found = 0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      cyc(1'b1, (i % 2 == 0));
      if (nf_out) begin
        found = 1;
        check("gap_nf_en", int'(en_in), 1);
        check("gap_nf_h", int'(h_count_out), 4);
        check("gap_nf_v", int'(v_count_out), 3);
        cyc(1'b1, 1'b0);
        check("gap_hold_nf", int'(nf_out), 0);
        check("gap_hold_h", int'(h_count_out), 4);
        check("gap_hold_v", int'(v_count_out), 3);
      end
    end
    check("gap_found", int'(found), 1);

    // random enables with occasional resets
    for (int i = 0; i < 800; i++)
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0));

    // 6. reset mid-operation at (6,2)
    found = 0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      cyc(1'b1, 1'b1);
      if (h_count_out == 6 && v_count_out == 2) found = 1;
    end
    check("mid_found", int'(found), 1);
    check("mid_hs", int'(hs_out), SACT);
    cyc(1'b0, 1'b1);
    check("mid_rst_h", int'(h_count_out), 0);
    check("mid_rst_hs", int'(hs_out), SINACT);
    check("mid_rst_ad", int'(ad_out), 0);
    check("mid_rst_fc", int'(fc_out), 0);
    cyc(1'b1, 1'b1);
    check("restart_h", int'(h_count_out), 0);
    check("restart_v", int'(v_count_out), 0);
    check("restart_ad", int'(ad_out), 1);
    check("restart_fc", int'(fc_out), 0);
    repeat (2) cyc(1'b1, 1'b1);

    // final report
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
